// File: rtl/byte_logic_pkg.sv
// Shared encodings for the byte logic sequencer: operation codes and FSM states.
package byte_logic_pkg;

    localparam logic [1:0] BL_AND = 2'd0;
    localparam logic [1:0] BL_OR  = 2'd1;
    localparam logic [1:0] BL_XOR = 2'd2;
    localparam logic [1:0] BL_NOT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } bl_state_e;

endpackage

// File: rtl/byte_logic_sequencer_if.sv
// Requester/consumer bundle for the byte logic sequencer.
// Handshake: a transfer happens on a rising edge where valid && ready; the source
// holds valid and payload until then, and ready never depends on payload.
interface byte_logic_sequencer_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic              rsp_zero;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
    );
endinterface

// File: rtl/byte_any_bit_set.sv
// Reduction OR: high when any bit of the byte is set.
module byte_any_bit_set (
    input  logic [7:0] a,
    output logic       any
);
    assign any = |a;
endmodule

// File: rtl/byte_bitwise_and.sv
// Per-bit AND gate array over one byte.
module byte_bitwise_and (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign y[i] = a[i] & b[i];
    end
endmodule

// File: rtl/byte_bitwise_not.sv
// Per-bit inverter array over one byte.
module byte_bitwise_not (
    input  logic [7:0] a,
    output logic [7:0] y
);
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign y[i] = ~a[i];
    end
endmodule

// File: rtl/byte_bitwise_or.sv
// Per-bit OR gate array over one byte.
module byte_bitwise_or (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign y[i] = a[i] | b[i];
    end
endmodule

// File: rtl/byte_logic_unit.sv
// Combinational byte logic datapath: AND/OR/XOR/NOT of A and B plus a zero flag.
module byte_logic_unit
    import byte_logic_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       zero
);
    logic [7:0] and_y;
    logic [7:0] or_y;
    logic [7:0] xor_y;
    logic [7:0] not_y;
    logic       any;

    byte_bitwise_and u_and (.a(a), .b(b), .y(and_y));
    byte_bitwise_or  u_or  (.a(a), .b(b), .y(or_y));
    byte_bitwise_not u_not (.a(a), .y(not_y));

    for (genvar i = 0; i < 8; i++) begin : g_xor
        assign xor_y[i] = a[i] ^ b[i];
    end

    always_comb begin
        y = and_y;
        case (op)
            BL_AND: y = and_y;
            BL_OR:  y = or_y;
            BL_XOR: y = xor_y;
            BL_NOT: y = not_y;
        endcase
    end

    byte_any_bit_set u_any (.a(y), .any(any));
    assign zero = ~any;
endmodule

// File: rtl/byte_logic_sequencer.sv
// Round-robin front end sharing one byte_logic_unit among NREQ requesters,
// one op in flight, registered result with its own handshake.
module byte_logic_sequencer
    import byte_logic_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    byte_logic_sequencer_if.slave        bus,
    output bl_state_e                    fsm_state
);
    bl_state_e       state;
    bl_state_e       state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic            accept;

    logic [1:0]      op_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [IDW-1:0]  id_q;

    logic [7:0]      f_y;
    logic            f_zero;

    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_zero_q;
    logic [IDW-1:0]  rsp_id_q;

    // Search starts just past the last winner so persistent requesters rotate.
    always_comb begin : arbiter
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
        grant[grant_idx] = grant_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        bus.req_ready = '0;
        accept        = 1'b0;
        if (rst_n && state == IDLE) begin
            bus.req_ready = grant;
            accept        = grant_any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDW'(NREQ - 1);
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
        end else if (accept) begin
            rr_ptr <= grant_idx;
            op_q   <= bus.req_op[2*int'(grant_idx) +: 2];
            a_q    <= bus.req_a[8*int'(grant_idx) +: 8];
            b_q    <= bus.req_b[8*int'(grant_idx) +: 8];
            id_q   <= grant_idx;
        end
    end

    byte_logic_unit u_unit (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .y    (f_y),
        .zero (f_zero)
    );

    // Result payload keeps its last value after the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b1;
            rsp_id_q    <= '0;
        end else if (state == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= f_y;
            rsp_zero_q  <= f_zero;
            rsp_id_q    <= id_q;
        end else if (state == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_id    = rsp_id_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_byte_logic_sequencer.sv
// Directed plus randomized bench for byte_logic_sequencer at NREQ=2 and NREQ=4.
module tb_byte_logic_sequencer;
    import byte_logic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    byte_logic_sequencer_if #(.NREQ(2), .IDW(1)) b2 ();
    byte_logic_sequencer_if #(.NREQ(4), .IDW(2)) b4 ();
    bl_state_e st2;
    bl_state_e st4;

    byte_logic_sequencer #(.NREQ(2), .IDW(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b2), .fsm_state(st2)
    );
    byte_logic_sequencer #(.NREQ(4), .IDW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .fsm_state(st4)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int last2;
    int last4;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Next winner: first valid index after the previous winner, wrapping.
    function automatic int rr_pick(input logic [7:0] vmask, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            if (vmask[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    task automatic set_req2(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        b2.req_op[2*i +: 2] = op;
        b2.req_a[8*i +: 8]  = a;
        b2.req_b[8*i +: 8]  = b;
        b2.req_valid[i]     = 1'b1;
    endtask

    // One full transaction on the NREQ=2 instance, called at a negedge in IDLE.
    task automatic serve2(input int stall, input bit keep);
        int n;
        int g;
        logic [7:0] d;
        logic [15:0] e;
        b2.rsp_ready = (stall == 0);
        #1;
        n = 0;
        while (!(|(b2.req_valid & b2.req_ready)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", 32'(n < 20), 32'd1);
        g = rr_pick(8'(b2.req_valid), last2, 2);
        check("grant_onehot", 32'(b2.req_ready), 32'(1 << g));
        d = ref_f(b2.req_op[2*g +: 2], b2.req_a[8*g +: 8], b2.req_b[8*g +: 8]);
        exp_q.push_back({7'(g), (d == 8'h00), d});
        last2 = g;
        @(posedge clk);
        @(negedge clk);
        if (!keep) b2.req_valid[g] = 1'b0;
        check("exec_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("exec_req_ready", 32'(b2.req_ready), 32'd0);
        check("exec_state", st2, EXEC);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rsp_valid", 32'(b2.rsp_valid), 32'd1);
        check("rsp_data", 32'(b2.rsp_data), 32'(e[7:0]));
        check("rsp_zero", 32'(b2.rsp_zero), 32'(e[8]));
        check("rsp_id", 32'(b2.rsp_id), 32'(e[15:9]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", 32'(b2.rsp_valid), 32'd1);
            check("hold_data", 32'(b2.rsp_data), 32'(e[7:0]));
            check("hold_zero", 32'(b2.rsp_zero), 32'(e[8]));
            check("hold_id", 32'(b2.rsp_id), 32'(e[15:9]));
            check("hold_req_ready", 32'(b2.req_ready), 32'd0);
        end
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_taken", 32'(b2.rsp_valid), 32'd0);
        check("back_idle", st2, IDLE);
    endtask

    initial begin
        int n;
        int g;
        logic [7:0] d;
        logic [7:0] ra;

        b2.req_valid = '1;
        b2.req_op = '0;
        b2.req_a = '0;
        b2.req_b = '0;
        b2.rsp_ready = 1'b1;
        b4.req_valid = '0;
        b4.req_op = '0;
        b4.req_a = '0;
        b4.req_b = '0;
        b4.rsp_ready = 1'b1;

        // Reset: requests present while reset is held must not be granted.
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("rst_rsp_zero", 32'(b2.rsp_zero), 32'd1);
        check("rst_rsp_data", 32'(b2.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(b2.rsp_id), 32'd0);
        check("rst_req_ready", 32'(b2.req_ready), 32'd0);
        check("rst4_rsp_zero", 32'(b4.rsp_zero), 32'd1);
        b2.req_valid = '0;
        rst_n = 1'b1;
        last2 = 1;
        last4 = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_req_ready", 32'(b2.req_ready), 32'd0);
            check("idle_state", st2, IDLE);
        end

        // Single ops, including a zero result and NOT ignoring B.
        set_req2(0, BL_AND, 8'hF0, 8'h3C);
        serve2(0, 1'b0);
        set_req2(0, BL_XOR, 8'hAA, 8'hAA);
        serve2(0, 1'b0);
        set_req2(1, BL_NOT, 8'h5A, 8'hFF);
        serve2(0, 1'b0);

        // Two persistent requesters alternate.
        set_req2(0, BL_XOR, 8'hC3, 8'h0F);
        set_req2(1, BL_OR, 8'h81, 8'h18);
        for (int i = 0; i < 4; i++) serve2(0, 1'b1);
        b2.req_valid = '0;

        // Backpressure with a competing request waiting.
        set_req2(0, BL_OR, 8'h0F, 8'h50);
        set_req2(1, BL_AND, 8'hFF, 8'h99);
        serve2(5, 1'b0);
        serve2(0, 1'b0);

        // NREQ=4, all persistent: expect rotation 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            b4.req_op[2*i +: 2] = 2'($urandom_range(0, 3));
            b4.req_a[8*i +: 8]  = 8'($urandom);
            b4.req_b[8*i +: 8]  = 8'($urandom);
        end
        b4.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!(|b4.req_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("g4_wait", 32'(n < 20), 32'd1);
            g = rr_pick(8'(b4.req_valid), last4, 4);
            last4 = g;
            check("g4_onehot", 32'(b4.req_ready), 32'(1 << g));
            d = ref_f(b4.req_op[2*g +: 2], b4.req_a[8*g +: 8], b4.req_b[8*g +: 8]);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b4.rsp_valid && n < 10);
            check("g4_rsp_valid", 32'(b4.rsp_valid), 32'd1);
            check("g4_id", 32'(b4.rsp_id), 32'(g));
            check("g4_data", 32'(b4.rsp_data), 32'(d));
            if (k == 4) b4.req_valid = '0;
            @(negedge clk);
        end

        // Reset during EXEC discards the op and restarts arbitration at 0.
        b2.rsp_ready = 1'b1;
        set_req2(0, BL_OR, 8'h12, 8'h34);
        #1;
        n = 0;
        while (!b2.req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_grant_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("mid_in_exec", st2, EXEC);
        rst_n = 1'b0;
        b2.req_valid = '0;
        #1;
        check("mid_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("mid_req_ready", 32'(b2.req_ready), 32'd0);
        check("mid_rsp_zero", 32'(b2.rsp_zero), 32'd1);
        check("mid_rsp_data", 32'(b2.rsp_data), 32'd0);
        check("mid_state", st2, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last2 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(b2.rsp_valid), 32'd0);
        end
        set_req2(0, BL_AND, 8'h77, 8'h1E);
        set_req2(1, BL_XOR, 8'h77, 8'h1E);
        serve2(0, 1'b0);
        b2.req_valid = '0;

        // Random traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!b2.req_valid[i] && $urandom_range(0, 2) != 0) begin
                    ra = 8'($urandom);
                    set_req2(i, 2'($urandom_range(0, 3)), ra,
                             ($urandom_range(0, 3) == 0) ? ra : 8'($urandom));
                end
            end
            if (b2.req_valid == 2'b00) set_req2(0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            serve2($urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
